// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder stage of the ripple-carry chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - four-stage ripple-carry adder with registered sum and carry out
module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [2:0] c;
    logic [3:0] s_next;
    logic       cout_next;

    // Carry ripples stage 0 -> 3; the cin-to-cout path is the critical one.
    full_adder u_fa0 (.a(a[0]), .b(b[0]), .cin(cin),  .s(s_next[0]), .cout(c[0]));
    full_adder u_fa1 (.a(a[1]), .b(b[1]), .cin(c[0]), .s(s_next[1]), .cout(c[1]));
    full_adder u_fa2 (.a(a[2]), .b(b[2]), .cin(c[1]), .s(s_next[2]), .cout(c[2]));
    full_adder u_fa3 (.a(a[3]), .b(b[3]), .cin(c[2]), .s(s_next[3]), .cout(cout_next));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= s_next;
            cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - scoreboard bench for adder_4bit with exhaustive shuffled sweep
module tb_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] value;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the sampled operands.
    function automatic logic [4:0] model(input bit rst, input int av, input int bv, input int cv);
        int total;
        total = av + bv + cv;
        if (rst)
            return 5'd0;
        return total[4:0];
    endfunction

    task automatic apply(input bit rst, input logic [3:0] av, input logic [3:0] bv,
                         input logic cv, input string name);
        exp_t e;
        @(negedge clk);
        rst_n = !rst;
        a     = av;
        b     = bv;
        cin   = cv;
        @(posedge clk);
        e.value = model(rst, int'(av), int'(bv), int'(cv));
        e.name  = name;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if ({cout, s} !== e.value) begin
                errors++;
                $display("FAIL %s: got cout=%b s=%b, expected cout=%b s=%b",
                         e.name, cout, s, e.value[4], e.value[3:0]);
            end
        end
    end

    logic [8:0] order[512];

    initial begin
        rst_n = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        cin   = 1'b0;

        apply(1'b1, 4'b1010, 4'b0101, 1'b1, "reset_0");
        apply(1'b1, 4'b1010, 4'b0101, 1'b1, "reset_1");

        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 4'(1 << i), 4'd0, 1'b0, $sformatf("conn_a%0d", i));
            apply(1'b0, 4'd0, 4'(1 << i), 1'b0, $sformatf("conn_b%0d", i));
        end
        apply(1'b0, 4'd0, 4'd0, 1'b1, "conn_cin");

        for (int i = 0; i < 4; i++)
            apply(1'b0, 4'(1 << i), 4'(1 << i), 1'b0, $sformatf("carry_link%0d", i));

        apply(1'b0, 4'b0000, 4'b0000, 1'b0, "crit_pre");
        apply(1'b0, 4'b1111, 4'b0000, 1'b1, "crit_path");
        apply(1'b0, 4'b1111, 4'b1111, 1'b1, "overflow");

        for (int i = 0; i < 512; i++)
            order[i] = 9'(i);
        for (int i = 511; i > 0; i--) begin
            int j;
            logic [8:0] t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end

        for (int i = 0; i < 512; i++) begin
            if (i == 200)
                apply(1'b1, order[i][3:0], order[i][7:4], order[i][8], "sweep_reset");
            apply(1'b0, order[i][3:0], order[i][7:4], order[i][8], $sformatf("sweep%0d", i));
        end

        for (int i = 0; i < 32; i++)
            apply(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rand%0d", i));

        for (int k = 0; k < 10 && sb_q.size() > 0; k++)
            @(posedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
